mem_verify: RTL and testbench
=============================

# mem_verify

Read-back checker for the 256-byte S-memory on the RC4 datapath. It performs the reader side of memory initialisation: on `start` it streams addresses 0..255 to the on-chip RAM and compares each returned byte against the identity pattern (`q == address`). It then reports pass/fail, the mismatch count and the first failing address. It sits beside the initialiser on the shared RAM port and runs after the initialiser's `finish`, before key scheduling.

## Interface
- `RD_LAT`, default 1: RAM read latency in cycles from `address` to valid `q`; legal values 1 or 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; sampled only in IDLE.
- `q`  in  8  RAM read data.
- `address`  out  8  RAM read address.
- `rd_en`  out  1  high while a read address is being issued.
- `finish`  out  1  scan complete; results valid while high.
- `pass`  out  1  1 when the scan found zero mismatches; meaningful only while `finish` is high.
- `err_count`  out  9  number of mismatching locations, 0..256.
- `first_err_addr`  out  8  address of the lowest mismatching location; 0 if none.

## Operation
- FSM states:
  - IDLE: `start` high → ISSUE; counters and results clear on this transition.
  - ISSUE: `address` increments by 1 per cycle, `rd_en`=1. After the cycle that issues address 255 → DRAIN.
  - DRAIN: wait RD_LAT cycles for the last read data → DONE.
  - DONE: `finish`=1 while `start` stays high. `start` low → IDLE on the next edge.
- Compare pipeline:
  - Issued address and a valid bit enter an RD_LAT-deep shift register.
  - When the delayed valid is high, compare `q` against the delayed address.
  - On mismatch, `err_count` +1. If this is the first mismatch, latch `first_err_addr`.
- Width rules:
  - Address counter is 8 bits. The ISSUE exit is decided on `address == 8'hFF`, never on wrap to 0.
  - `err_count` is 9 bits, so 256 mismatches are representable with no saturation logic.
- `pass` is registered as (`err_count == 0`) on entry to DONE.
- Reset values (any time, including mid-scan): state IDLE, `address`=0, `rd_en`=0, `finish`=0, `pass`=0, `err_count`=0, `first_err_addr`=0, pipeline valid bits cleared. No partial result survives a reset.
- `start` asserted in ISSUE, DRAIN or DONE is ignored.
- A new scan requires a low→high `start` pass through IDLE. Holding `start` high keeps DONE and the results stable.

## Timing
- Let edge S be the edge at which `start` is sampled high in IDLE.
- Address k is driven in the cycle after edge S+k, for k = 0..255.
- Data for address k is compared at edge S+k+RD_LAT+1.
- `finish` rises after edge S+257+RD_LAT, i.e. S+258 for RD_LAT=1 and S+259 for RD_LAT=2.
- Results change only at compare edges. They are stable from `finish` rising until the next scan starts.
- `finish` falls one edge after `start` is sampled low in DONE.
- Throughput is one address per cycle; there are no wait states within ISSUE.

## Structure
- Shared package `rc4_mem_pkg`:
  - `MEM_ADDR_W`=8, `MEM_DATA_W`=8, `MEM_DEPTH`=256.
  - The FSM state enum for this block.
  - The expected-value function (identity), also used by the initialiser's testbench.
- Sub-module `rd_delay_line`: parameterised RD_LAT-stage shift register carrying {valid, address}. It resets asynchronously to all-zero.

## Test plan
- Identity RAM, RD_LAT=1, pulse `start` → `finish` after edge S+258, `pass`=1, `err_count`=0, `first_err_addr`=0.
- RAM[0x5A]=0x00, all else identity → `err_count`=1, `first_err_addr`=0x5A, `pass`=0.
- RAM[0x03]=0xFF and RAM[0xF0]=0x0F → `err_count`=2, `first_err_addr`=0x03. An all-zero RAM gives `err_count`=255 and `first_err_addr`=0x01.
- RD_LAT=2, identity RAM → `pass`=1 and `finish` rises one cycle later than with RD_LAT=1. Corrupting RAM[0xFF] alone gives `err_count`=1 and `first_err_addr`=0xFF, proving the last read is drained.
- Assert `rst` low while `address`=0x80 → all outputs at reset values immediately, and `finish` never rises. A following `start` runs a complete clean scan.
- Hold `start` high through DONE → `finish` and results stay stable. Drop `start` → IDLE. Re-raise `start` with RAM[0x10] corrupted → counters cleared, then `err_count`=1 and `first_err_addr`=0x10.

Source files
------------

// File: rtl/rc4_mem_pkg.sv
// Shared definitions for the RC4 S-memory datapath: memory geometry,
// the read-back checker state encoding and the expected-content function.
package rc4_mem_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 8;
   localparam int MEM_DEPTH  = 256;

   typedef enum logic [1:0] {
      MV_IDLE  = 2'd0,
      MV_ISSUE = 2'd1,
      MV_DRAIN = 2'd2,
      MV_DONE  = 2'd3
   } mv_state_e;

   // After initialisation every location holds its own address.
   function automatic logic [MEM_DATA_W-1:0] mem_expected(input logic [MEM_ADDR_W-1:0] addr);
      return addr;
   endfunction

endpackage

// File: rtl/mem_verify_if.sv
// Control and RAM-read bundle for the S-memory read-back checker.
interface mem_verify_if;
   import rc4_mem_pkg::*;

   logic                  start;
   logic [MEM_DATA_W-1:0] q;
   logic [MEM_ADDR_W-1:0] address;
   logic                  rd_en;
   logic                  finish;
   logic                  pass;
   logic [MEM_ADDR_W:0]   err_count;
   logic [MEM_ADDR_W-1:0] first_err_addr;

   modport master (
      output start, q,
      input  address, rd_en, finish, pass, err_count, first_err_addr
   );

   modport slave (
      input  start, q,
      output address, rd_en, finish, pass, err_count, first_err_addr
   );

endinterface

// File: rtl/rd_delay_line.sv
// LAT-stage shift register aligning issued {valid, address} with the RAM
// read data that returns LAT cycles later.
module rd_delay_line #(
   parameter int LAT = 1,
   parameter int AW  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr
);

   logic [LAT-1:0] vld_r;
   logic [AW-1:0]  addr_r [LAT];

   // Shift stage 0 toward stage LAT-1 each cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_r <= '0;
         for (int i = 0; i < LAT; i++) begin
            addr_r[i] <= '0;
         end
      end else begin
         vld_r[0]  <= in_valid;
         addr_r[0] <= in_addr;
         for (int i = 1; i < LAT; i++) begin
            vld_r[i]  <= vld_r[i-1];
            addr_r[i] <= addr_r[i-1];
         end
      end
   end

   assign out_valid = vld_r[LAT-1];
   assign out_addr  = addr_r[LAT-1];

endmodule

// File: rtl/mem_verify.sv
// Read-back checker for the RC4 S-memory: scans addresses 0..255 and checks
// each returned byte against the identity pattern, reporting count and first error.
module mem_verify
   import rc4_mem_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   mem_verify_if.slave bus
);

   localparam logic [1:0] IDLE  = MV_IDLE;
   localparam logic [1:0] ISSUE = MV_ISSUE;
   localparam logic [1:0] DRAIN = MV_DRAIN;
   localparam logic [1:0] DONE  = MV_DONE;

   localparam logic [MEM_ADDR_W-1:0] LAST_ADDR  = MEM_ADDR_W'(MEM_DEPTH - 1);
   localparam logic [1:0]            DRAIN_LAST = 2'(RD_LAT);

   logic [1:0]            state_r;
   logic [1:0]            drain_cnt_r;
   logic [MEM_ADDR_W-1:0] address_r;
   logic                  rd_en_r;
   logic                  finish_r;
   logic                  pass_r;
   logic [MEM_ADDR_W:0]   err_count_r;
   logic [MEM_ADDR_W-1:0] first_err_r;

   logic                  dly_valid_s;
   logic [MEM_ADDR_W-1:0] dly_addr_s;
   logic                  scan_start_s;
   logic                  mismatch_s;

   rd_delay_line #(
      .LAT (RD_LAT),
      .AW  (MEM_ADDR_W)
   ) u_dly (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_en_r),
      .in_addr   (address_r),
      .out_valid (dly_valid_s),
      .out_addr  (dly_addr_s)
   );

   assign scan_start_s = (state_r == IDLE) && bus.start;
   assign mismatch_s   = dly_valid_s && (bus.q != mem_expected(dly_addr_s));

   // Scan sequencer: issue 256 addresses, wait out the last read, then hold DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         drain_cnt_r <= 2'd0;
         address_r   <= '0;
         rd_en_r     <= 1'b0;
         finish_r    <= 1'b0;
         pass_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  state_r   <= ISSUE;
                  address_r <= '0;
                  rd_en_r   <= 1'b1;
                  pass_r    <= 1'b0;
               end
            end
            ISSUE: begin
               // Exit on the last address itself; the counter never wraps.
               if (address_r == LAST_ADDR) begin
                  state_r     <= DRAIN;
                  rd_en_r     <= 1'b0;
                  drain_cnt_r <= 2'd0;
               end else begin
                  address_r <= address_r + 8'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt_r == DRAIN_LAST) begin
                  state_r  <= DONE;
                  finish_r <= 1'b1;
                  pass_r   <= (err_count_r == '0);
               end else begin
                  drain_cnt_r <= drain_cnt_r + 2'd1;
               end
            end
            DONE: begin
               if (!bus.start) begin
                  state_r  <= IDLE;
                  finish_r <= 1'b0;
               end
            end
            default: begin
               state_r  <= IDLE;
               rd_en_r  <= 1'b0;
               finish_r <= 1'b0;
            end
         endcase
      end
   end

   // Result accumulation: cleared when a scan starts, updated only at compare edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count_r <= '0;
         first_err_r <= '0;
      end else if (scan_start_s) begin
         err_count_r <= '0;
         first_err_r <= '0;
      end else if (mismatch_s) begin
         err_count_r <= err_count_r + 9'd1;
         if (err_count_r == '0) begin
            first_err_r <= dly_addr_s;
         end
      end
   end

   assign bus.address        = address_r;
   assign bus.rd_en          = rd_en_r;
   assign bus.finish         = finish_r;
   assign bus.pass           = pass_r;
   assign bus.err_count      = err_count_r;
   assign bus.first_err_addr = first_err_r;

endmodule

// File: tb/tb_mem_verify.sv
// Bench for mem_verify: RD_LAT=1 and RD_LAT=2 instances share one RAM image;
// table-driven scans plus reset-mid-scan and held-start sequences.
module tb_mem_verify;

   typedef struct packed {
      logic [8:0] err;
      logic [7:0] first;
      logic       pass;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic       p0_en;
      logic [7:0] p0_a;
      logic [7:0] p0_d;
      logic       p1_en;
      logic [7:0] p1_a;
      logic [7:0] p1_d;
      exp_t       exp;
   } vec_t;

   typedef struct packed {
      logic [7:0] address;
      logic       rd_en;
      logic       finish;
      logic       pass;
      logic [8:0] err;
      logic [7:0] first;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] mem [256];
   logic [7:0] pipe2_r;
   exp_t       sb [2][$];
   vec_t       vecs [7];

   mem_verify_if bus1 ();
   mem_verify_if bus2 ();

   mem_verify #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   mem_verify #(.RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   always #5 clk = ~clk;

   // RAM models with one and two cycles of read latency.
   always @(posedge clk) begin
      bus1.q  <= mem[bus1.address];
      pipe2_r <= mem[bus2.address];
      bus2.q  <= pipe2_r;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic obs_t obs(input int d);
      if (d == 1) begin
         return {bus1.address, bus1.rd_en, bus1.finish, bus1.pass, bus1.err_count, bus1.first_err_addr};
      end
      return {bus2.address, bus2.rd_en, bus2.finish, bus2.pass, bus2.err_count, bus2.first_err_addr};
   endfunction

   task automatic fill_mem(input logic [1:0] mode);
      for (int a = 0; a < 256; a++) begin
         case (mode)
            2'd1:    mem[a] = 8'h00;
            2'd2:    mem[a] = ~8'(a);
            default: mem[a] = 8'(a);
         endcase
      end
   endtask

   task automatic check_reset(input string tag);
      for (int d = 1; d <= 2; d++) begin
         check($sformatf("%s_d%0d_outputs", tag, d), 32'(obs(d)), 32'h0);
      end
   endtask

   // Pulse (or hold) start, then watch both instances until each raises finish.
   task automatic scan(input bit hold);
      bit   seen [2];
      int   n;
      obs_t o;
      exp_t e;
      seen[0] = 1'b0;
      seen[1] = 1'b0;
      @(negedge clk);
      bus1.start = 1'b1;
      bus2.start = 1'b1;
      @(posedge clk);
      n = 0;
      while (!(seen[0] && seen[1]) && n < 400) begin
         @(negedge clk);
         if (!hold) begin
            bus1.start = 1'b0;
            bus2.start = 1'b0;
         end
         for (int d = 1; d <= 2; d++) begin
            o = obs(d);
            if (n == 0) begin
               check($sformatf("d%0d_start_clear", d), {o.address, o.rd_en, o.err, o.first, o.pass},
                     {8'h00, 1'b1, 9'd0, 8'h00, 1'b0});
            end
            if (n == 128 || n == 255) begin
               check($sformatf("d%0d_issue_addr_%0d", d, n), {o.address, o.rd_en}, {n[7:0], 1'b1});
            end
            if (n == 256) begin
               check($sformatf("d%0d_rd_en_drop", d), 32'(o.rd_en), 32'd0);
            end
            if (!seen[d-1] && o.finish) begin
               seen[d-1] = 1'b1;
               check($sformatf("d%0d_finish_edge", d), n, 257 + d);
               if (sb[d-1].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL d%0d_scoreboard unexpected finish, no expected result queued", d);
               end else begin
                  e = sb[d-1].pop_front();
                  check($sformatf("d%0d_result", d), {o.err, o.first, o.pass}, e);
               end
            end
         end
         @(posedge clk);
         n++;
      end
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_finish_seen", d + 1), 32'(seen[d]), 32'd1);
      end
   endtask

   initial begin
      bit   seen_fin;
      obs_t o;

      vecs[0] = '{2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, '{9'd0,   8'h00, 1'b1}};
      vecs[1] = '{2'd0, 1'b1, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, '{9'd1,   8'h5A, 1'b0}};
      vecs[2] = '{2'd0, 1'b1, 8'h03, 8'hFF, 1'b1, 8'hF0, 8'h0F, '{9'd2,   8'h03, 1'b0}};
      vecs[3] = '{2'd1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, '{9'd255, 8'h01, 1'b0}};
      vecs[4] = '{2'd0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, '{9'd1,   8'hFF, 1'b0}};
      vecs[5] = '{2'd2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, '{9'd256, 8'h00, 1'b0}};
      vecs[6] = '{2'd0, 1'b1, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, '{9'd1,   8'h00, 1'b0}};

      rst        = 1'b1;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      fill_mem(2'd0);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("por");
      rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         fill_mem(vecs[i].mode);
         if (vecs[i].p0_en) mem[vecs[i].p0_a] = vecs[i].p0_d;
         if (vecs[i].p1_en) mem[vecs[i].p1_a] = vecs[i].p1_d;
         sb[0].push_back(vecs[i].exp);
         sb[1].push_back(vecs[i].exp);
         scan(1'b0);
      end

      // Reset in the middle of a scan: no partial result, no finish.
      fill_mem(2'd0);
      @(negedge clk);
      bus1.start = 1'b1;
      bus2.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      repeat (128) @(negedge clk);
      check("d1_addr_before_rst", 32'(bus1.address), 32'h80);
      check("d2_addr_before_rst", 32'(bus2.address), 32'h80);
      rst = 1'b0;
      #1;
      check_reset("midscan_rst");
      @(negedge clk);
      rst = 1'b1;
      seen_fin = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (bus1.finish || bus2.finish) seen_fin = 1'b1;
      end
      check("no_finish_after_rst", 32'(seen_fin), 32'd0);
      sb[0].push_back('{9'd0, 8'h00, 1'b1});
      sb[1].push_back('{9'd0, 8'h00, 1'b1});
      scan(1'b0);

      // Held start keeps DONE and results stable; a fresh scan clears them.
      mem[8'h20] = 8'h00;
      sb[0].push_back('{9'd1, 8'h20, 1'b0});
      sb[1].push_back('{9'd1, 8'h20, 1'b0});
      scan(1'b1);
      repeat (5) begin
         @(negedge clk);
         for (int d = 1; d <= 2; d++) begin
            o = obs(d);
            check($sformatf("d%0d_done_hold", d), {o.finish, o.err, o.first, o.pass},
                  {1'b1, 9'd1, 8'h20, 1'b0});
         end
      end
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      @(negedge clk);
      check("d1_finish_fall", 32'(bus1.finish), 32'd0);
      check("d2_finish_fall", 32'(bus2.finish), 32'd0);
      fill_mem(2'd0);
      mem[8'h10] = 8'h00;
      sb[0].push_back('{9'd1, 8'h10, 1'b0});
      sb[1].push_back('{9'd1, 8'h10, 1'b0});
      scan(1'b0);

      check("d1_sb_drained", 32'(sb[0].size()), 32'd0);
      check("d2_sb_drained", 32'(sb[1].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
